// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared constants and helpers for the timer control block
package timer_pkg;

    localparam int PCNT_W        = 8;
    localparam int TIMER_DIV_MAX = 8;

    localparam logic [11:0] ADDR_TCR   = 12'h000;
    localparam logic [11:0] ADDR_TDR0  = 12'h004;
    localparam logic [11:0] ADDR_TDR1  = 12'h008;
    localparam logic [11:0] ADDR_TCMP0 = 12'h00C;
    localparam logic [11:0] ADDR_TCMP1 = 12'h010;
    localparam logic [11:0] ADDR_TIER  = 12'h014;
    localparam logic [11:0] ADDR_TISR  = 12'h018;
    localparam logic [11:0] ADDR_THCSR = 12'h01C;

    localparam int TIMER_EN_BIT = 0;
    localparam int DIV_EN_BIT   = 1;
    localparam int DIV_VAL_LSB  = 8;
    localparam int DIV_VAL_MSB  = 11;

    localparam logic [3:0]  RST_DIV_VAL = 4'd1;
    localparam logic [63:0] RST_COMPARE = 64'hFFFF_FFFF_FFFF_FFFF;

    // Last pcnt value of a 2^div_val period; div_val=0 yields 0 (strobe every cycle).
    function automatic logic [PCNT_W-1:0] prescale_last(input logic [3:0] div_val);
        logic [PCNT_W:0] span;
        span = (PCNT_W+1)'(1) << div_val;
        return PCNT_W'(span - (PCNT_W+1)'(1));
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - 2^N prescaler producing the registered count strobe
module timer_prescaler
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       timer_en,
    input  logic       div_en,
    input  logic [3:0] div_val,
    input  logic       halted,
    input  logic       clr,
    output logic       cnt_en
);

    logic [PCNT_W-1:0] pcnt;
    logic              at_last;

    assign at_last = (pcnt == prescale_last(div_val));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt   <= '0;
            cnt_en <= 1'b0;
        end else if (clr || !timer_en) begin
            pcnt   <= '0;
            cnt_en <= 1'b0;
        end else if (halted) begin
            cnt_en <= 1'b0;
        end else if (!div_en) begin
            cnt_en <= 1'b1;
        end else begin
            cnt_en <= at_last;
            pcnt   <= at_last ? '0 : pcnt + PCNT_W'(1);
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - timer control registers, compare interrupt and halt handling
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int DIV_MAX = TIMER_DIV_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              pslverr,
    input  logic [63:0]       cnt_value,
    input  logic              dbg_mode,
    output logic              timer_en,
    output logic              cnt_en,
    output logic              tim_int
);

    logic        tcr_timer_en;
    logic        tcr_div_en;
    logic [3:0]  tcr_div_val;
    logic [63:0] compare;
    logic        int_en;
    logic        int_st;
    logic        halt_req;
    logic        halt_ack;

    logic        wr_tcr;
    logic        tcr_reject;
    logic        tcr_accept;
    logic        w1c_int;
    logic        cmp_hit;
    logic [3:0]  wr_div_val;
    logic [31:0] rd_word;

    assign wr_div_val = wdata[DIV_VAL_MSB:DIV_VAL_LSB];
    assign wr_tcr     = wr_en && (addr == ADDR_W'(ADDR_TCR));
    // While running, only timer_en may change; anything else drops the whole write.
    assign tcr_reject = wr_tcr && ((int'(wr_div_val) > DIV_MAX) ||
                        (tcr_timer_en && ((wdata[DIV_EN_BIT] != tcr_div_en) ||
                                          (wr_div_val != tcr_div_val))));
    assign tcr_accept = wr_tcr && !tcr_reject;
    assign w1c_int    = wr_en && (addr == ADDR_W'(ADDR_TISR)) && wdata[0];
    assign cmp_hit    = tcr_timer_en && (cnt_value == compare);
    assign halt_ack   = dbg_mode && halt_req;
    assign timer_en   = tcr_timer_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcr_timer_en <= 1'b0;
            tcr_div_en   <= 1'b0;
            tcr_div_val  <= RST_DIV_VAL;
            compare      <= RST_COMPARE;
            int_en       <= 1'b0;
            int_st       <= 1'b0;
            halt_req     <= 1'b0;
            tim_int      <= 1'b0;
            pslverr      <= 1'b0;
        end else begin
            pslverr <= tcr_reject;
            if (tcr_accept) begin
                tcr_timer_en <= wdata[TIMER_EN_BIT];
                tcr_div_en   <= wdata[DIV_EN_BIT];
                tcr_div_val  <= wr_div_val;
            end
            if (wr_en && (addr == ADDR_W'(ADDR_TCMP0))) compare[31:0]  <= wdata[31:0];
            if (wr_en && (addr == ADDR_W'(ADDR_TCMP1))) compare[63:32] <= wdata[31:0];
            if (wr_en && (addr == ADDR_W'(ADDR_TIER)))  int_en         <= wdata[0];
            if (wr_en && (addr == ADDR_W'(ADDR_THCSR))) halt_req       <= wdata[0];
            // A compare hit on the same cycle as a clear keeps the status set.
            int_st  <= cmp_hit || (int_st && !w1c_int);
            tim_int <= int_st && int_en;
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_en) begin
            case (addr)
                ADDR_W'(ADDR_TCR):   rd_word = {20'b0, tcr_div_val, 6'b0, tcr_div_en, tcr_timer_en};
                ADDR_W'(ADDR_TDR0):  rd_word = cnt_value[31:0];
                ADDR_W'(ADDR_TDR1):  rd_word = cnt_value[63:32];
                ADDR_W'(ADDR_TCMP0): rd_word = compare[31:0];
                ADDR_W'(ADDR_TCMP1): rd_word = compare[63:32];
                ADDR_W'(ADDR_TIER):  rd_word = {31'b0, int_en};
                ADDR_W'(ADDR_TISR):  rd_word = {31'b0, int_st};
                ADDR_W'(ADDR_THCSR): rd_word = {30'b0, halt_ack, halt_req};
                default:             rd_word = '0;
            endcase
        end
    end

    assign rdata = DATA_W'(rd_word);

    timer_prescaler u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .timer_en (tcr_timer_en),
        .div_en   (tcr_div_en),
        .div_val  (tcr_div_val),
        .halted   (halt_ack),
        .clr      (tcr_accept),
        .cnt_en   (cnt_en)
    );

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - directed and random checks of timer_ctrl against a cycle model
module tb_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, wr_en, rd_en, dbg_mode;
    logic [11:0] addr;
    logic [31:0] wdata, rdata;
    logic [63:0] cnt_value;
    logic        pslverr, timer_en, cnt_en, tim_int;

    always #5 clk = ~clk;

    timer_ctrl dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wdata(wdata), .rdata(rdata), .pslverr(pslverr), .cnt_value(cnt_value),
        .dbg_mode(dbg_mode), .timer_en(timer_en), .cnt_en(cnt_en), .tim_int(tim_int)
    );

    // Reference state: register fields, strobe phase, and the counter the bench emulates.
    bit          m_ten, m_den, m_ien, m_ist, m_tim, m_hreq, m_perr, m_cen;
    int          m_dval, m_ticks;
    logic [63:0] m_cmp, m_cnt;
    int          total, bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ten = 0; m_den = 0; m_dval = 1; m_cmp = '1;
        m_ien = 0; m_ist = 0; m_tim = 0; m_hreq = 0; m_perr = 0; m_cen = 0; m_ticks = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h000: return {20'b0, 4'(m_dval), 6'b0, m_den, m_ten};
            12'h004: return cnt_value[31:0];
            12'h008: return cnt_value[63:32];
            12'h00C: return m_cmp[31:0];
            12'h010: return m_cmp[63:32];
            12'h014: return {31'b0, m_ien};
            12'h018: return {31'b0, m_ist};
            12'h01C: return {30'b0, dbg_mode & m_hreq, m_hreq};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        bit halted, hit, w1c, wr_tcr, rej, clr, n_cen;
        halted = dbg_mode && m_hreq;
        hit    = m_ten && (cnt_value == m_cmp);
        w1c    = wr_en && addr == 12'h018 && wdata[0];
        wr_tcr = wr_en && addr == 12'h000;
        rej    = wr_tcr && (wdata[11:8] > 8 ||
                 (m_ten && (wdata[1] != m_den || wdata[11:8] != m_dval)));
        clr    = wr_tcr && !rej;
        m_cnt  = m_cnt + (m_cen ? 64'd1 : 64'd0);
        if (clr || !m_ten) begin
            m_ticks = 0; n_cen = 0;
        end else if (halted) begin
            n_cen = 0;
        end else begin
            m_ticks++;
            n_cen = m_den ? ((m_ticks % (1 << m_dval)) == 0) : 1;
        end
        m_cen  = n_cen;
        m_tim  = m_ist && m_ien;
        m_ist  = hit || (m_ist && !w1c);
        m_perr = rej;
        if (clr) begin
            m_ten = wdata[0]; m_den = wdata[1]; m_dval = int'(wdata[11:8]);
        end
        if (wr_en) begin
            case (addr)
                12'h00C: m_cmp[31:0]  = wdata;
                12'h010: m_cmp[63:32] = wdata;
                12'h014: m_ien        = wdata[0];
                12'h01C: m_hreq       = wdata[0];
                default: ;
            endcase
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        chk("timer_en", timer_en, m_ten);
        chk("cnt_en", cnt_en, m_cen);
        chk("tim_int", tim_int, m_tim);
        chk("pslverr", pslverr, m_perr);
        cnt_value = m_cnt;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        wr_en = 1; addr = a; wdata = d;
        cycle();
        wr_en = 0; addr = 0; wdata = 0;
    endtask

    task automatic rd_exp(input logic [11:0] a, input logic [31:0] exp);
        rd_en = 1; addr = a;
        #1;
        chk($sformatf("rd_%03h", a), rdata, exp);
        cycle();
        rd_en = 0; addr = 0;
    endtask

    task automatic rd(input logic [11:0] a);
        rd_en = 1; addr = a;
        #1;
        chk($sformatf("rdm_%03h", a), rdata, m_read(a));
        cycle();
        rd_en = 0; addr = 0;
    endtask

    initial begin
        int first, pulses, op, i;
        logic [31:0] d;
        total = 0; bad = 0;
        rst_n = 0; wr_en = 0; rd_en = 0; addr = 0; wdata = 0; dbg_mode = 0;
        m_cnt = 0; cnt_value = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_timer_en", timer_en, 0);
        chk("rst_cnt_en", cnt_en, 0);
        chk("rst_tim_int", tim_int, 0);
        chk("rst_pslverr", pslverr, 0);
        rst_n = 1;

        // Reset register values
        rd_exp(12'h000, 32'h100);
        rd_exp(12'h004, 32'h0);
        rd_exp(12'h008, 32'h0);
        rd_exp(12'h00C, 32'hFFFF_FFFF);
        rd_exp(12'h010, 32'hFFFF_FFFF);
        rd_exp(12'h014, 32'h0);
        rd_exp(12'h018, 32'h0);
        rd_exp(12'h01C, 32'h0);
        rd_exp(12'h020, 32'h0);

        // Running timer rejects a div change
        wr(12'h000, 32'h3);
        wr(12'h000, 32'h301);
        chk("t2_pslverr_pulse", pslverr, 1);
        cycle();
        chk("t2_pslverr_drop", pslverr, 0);
        rd_exp(12'h000, 32'h3);
        chk("t2_cnt_en_div0", cnt_en, 1);

        // div_val=2 strobe cadence
        wr(12'h000, 32'h2);
        wr(12'h000, 32'h202);
        wr(12'h000, 32'h203);
        first = -1; pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (cnt_en) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        chk("t3_first_pulse", first, 4);
        chk("t3_pulses", pulses, 5);

        // Oversized div_val
        wr(12'h000, 32'h902);
        chk("t4_pslverr", pslverr, 1);
        rd_exp(12'h000, 32'h203);

        // Compare interrupt with same-cycle set/clear
        wr(12'h000, 32'h202);
        wr(12'h000, 32'h200);
        m_cnt = 3; cnt_value = m_cnt;
        wr(12'h00C, 32'd10);
        wr(12'h010, 32'd0);
        wr(12'h014, 32'd1);
        wr(12'h000, 32'h201);
        for (i = 0; i < 40 && cnt_value != 64'd10; i++) cycle();
        chk("t5_reach_cmp", cnt_value, 64'd10);
        wr(12'h018, 32'h1);
        chk("t5_tim_int_lag", tim_int, 0);
        cycle();
        chk("t5_tim_int_set", tim_int, 1);
        rd_exp(12'h018, 32'h1);
        idle(2);
        wr(12'h018, 32'h1);
        rd_exp(12'h018, 32'h0);
        chk("t5_tim_int_clr", tim_int, 0);

        // Debug halt
        wr(12'h000, 32'h200);
        wr(12'h000, 32'h202);
        wr(12'h000, 32'h203);
        idle(6);
        wr(12'h01C, 32'h1);
        rd_exp(12'h01C, 32'h1);
        pulses = 0;
        repeat (8) begin cycle(); if (cnt_en) pulses++; end
        chk("t6_no_halt_pulses", pulses, 2);
        dbg_mode = 1;
        rd_exp(12'h01C, 32'h3);
        pulses = 0;
        repeat (5) begin cycle(); if (cnt_en) pulses++; end
        chk("t6_halt_pulses", pulses, 0);
        dbg_mode = 0;
        idle(12);
        wr(12'h01C, 32'h0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 9);
            case (op)
                0: begin
                    if ($urandom_range(0, 1) == 0)
                        d = {20'b0, 4'(m_dval), 6'b0, m_den, 1'($urandom_range(0, 1))};
                    else
                        d = ($urandom & 32'hFFFF_F0FC) | (32'($urandom_range(0, 10)) << 8) |
                            32'($urandom_range(0, 3));
                    wr(12'h000, d);
                end
                1: wr(12'h00C, m_cnt[31:0] + 32'($urandom_range(0, 20)));
                2: wr(12'h010, m_cnt[63:32]);
                3: wr(12'h014, $urandom);
                4: wr(12'h018, $urandom);
                5: wr(12'h01C, $urandom);
                6: rd(12'($urandom_range(0, 9) * 4));
                7: wr(12'($urandom_range(1, 1023) * 4), $urandom);
                8: begin dbg_mode = ($urandom_range(0, 3) == 0); cycle(); end
                default: idle($urandom_range(1, 6));
            endcase
        end

        // Asynchronous reset while counting
        dbg_mode = 0;
        wr(12'h01C, 32'h0);
        wr(12'h000, {20'b0, 4'(m_dval), 6'b0, m_den, 1'b0});
        wr(12'h000, 32'h1);
        idle(2);
        chk("ar_cnt_en_before", cnt_en, 1);
        #2;
        rst_n = 0;
        #1;
        chk("ar_timer_en", timer_en, 0);
        chk("ar_cnt_en", cnt_en, 0);
        chk("ar_pslverr", pslverr, 0);
        chk("ar_tim_int", tim_int, 0);
        rd_en = 1; addr = 12'h000;
        #1;
        chk("ar_tcr", rdata, 32'h100);
        rd_en = 0; addr = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        rd_exp(12'h00C, 32'hFFFF_FFFF);
        rd_exp(12'h000, 32'h100);
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
Control and scheduling block for the 64-bit timer counter. It holds the control, compare, interrupt and debug-halt registers and generates the counter's `timer_en` and `cnt_en` strobes from a programmable 2^N prescaler. It compares the live `cnt_value` against a 64-bit compare value to raise a sticky interrupt. It sits beside the counter on the same register bus and owns every register except TDR0/TDR1, which it only reads back.

Parameters:
ADDR_W, 12, register address width
DATA_W, 32, register data width
DIV_MAX, 8, largest legal div_val; prescale period = 2^div_val cycles

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  register write strobe, one cycle per access
rd_en  in  1  register read strobe
addr  in  12  byte address of access
wdata  in  32  write data
rdata  out  32  read data, combinational, valid while rd_en=1
pslverr  out  1  registered error pulse for a rejected write
cnt_value  in  64  live counter value from the counter block
dbg_mode  in  1  CPU in debug state
timer_en  out  1  TCR.timer_en, to counter
cnt_en  out  1  count strobe, to counter
tim_int  out  1  interrupt, level

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Register map, unmapped addresses read 0 and writes to them are ignored:
  - 0x000 TCR: bit0 timer_en, bit1 div_en, bits[11:8] div_val.
  - 0x004 TDR0 and 0x008 TDR1: read cnt_value[31:0] and [63:32]; the write is handled by the counter and ignored here.
  - 0x00C TCMP0 and 0x010 TCMP1: compare[31:0] and [63:32].
  - 0x014 TIER: bit0 int_en.
  - 0x018 TISR: bit0 int_st, write-1-to-clear.
  - 0x01C THCSR: bit0 halt_req (RW), bit1 halt_ack (RO) = dbg_mode & halt_req.
- Reset values:
  - TCR = 0x0000_0100 (div_val=1).
  - compare = all ones; TIER = 0, TISR = 0, THCSR = 0.
  - Outputs timer_en, cnt_en, tim_int, pslverr are all 0.
- TCR write rejection: the whole TCR write is dropped and pslverr=1 for exactly one cycle following the write when either of these holds:
  - wdata[11:8] > DIV_MAX;
  - timer_en=1 (current value) and wdata div_en or div_val differs from current.
- TCR write acceptance: a write that only toggles timer_en is always accepted.
- Prescaler (timer_prescaler), internal counter pcnt of width 8:
  - pcnt is held at 0 while timer_en=0. It is also forced to 0 on any accepted TCR write.
  - halted = halt_ack. While halted, pcnt is frozen and cnt_en=0.
  - div_en=0: cnt_en = timer_en & ~halted, every cycle.
  - div_en=1: pcnt counts 0..2^div_val-1 and wraps. cnt_en = timer_en & ~halted & (pcnt == 2^div_val-1). div_val=0 gives cnt_en every cycle.
  - cnt_en is registered. The first strobe comes 2^div_val cycles after timer_en is sampled high.
- Interrupt:
  - int_st sets in any cycle where timer_en=1 and cnt_value == compare (full 64-bit compare).
  - A set and a W1C on the same cycle leave int_st=1 (set wins).
  - tim_int = int_st & int_en, registered one cycle after int_st.
  - Writes to TCMP0/1 take effect on the next cycle's compare.
- Asynchronous reset mid-operation returns every register to its reset value immediately. cnt_en drops in the same cycle.

Decomposition:
- Shared package timer_pkg:
  - address constants ADDR_TCR..ADDR_THCSR;
  - TCR bit positions (TIMER_EN_BIT, DIV_EN_BIT, DIV_VAL_LSB/MSB);
  - DIV_MAX and reset constants.
- Sub-module timer_prescaler:
  - inputs: clk, rst_n, timer_en, div_en, div_val, halted, clr;
  - output: cnt_en.
- Register file, compare and interrupt logic stay in timer_ctrl.

Test Plan:
1. Reset, then read all 8 addresses -> TCR=0x100, TCMP0/1=0xFFFF_FFFF, others 0; timer_en=cnt_en=tim_int=0.
2. Write TCR=0x0000_0003 (div_en=1, div_val=0), then TCR=0x0301 -> first write ok; second rejected with pslverr pulse; TCR reads 0x003; cnt_en high every cycle.
3. Write TCR=0x0203 with timer_en=0 first (0x0202 then 0x0203) -> cnt_en pulses every 4th cycle, first pulse 4 cycles after timer_en rises; counter reaches 5 after 20 cycles.
4. Write TCR=0x0902 -> rejected, pslverr=1 one cycle, TCR unchanged.
5. TCMP0=10, TCMP1=0, TIER=1, div_en=0, timer_en=1, cnt_value reaches 10:
   - int_st=1, then tim_int=1 one cycle later;
   - W1C TISR on the same cycle cnt_value==10 -> int_st remains 1;
   - a later W1C -> tim_int=0.
6. THCSR=1 with dbg_mode=1 for 6 cycles mid-count at div_val=2:
   - halt_ack=1, cnt_en=0, pcnt frozen;
   - after dbg_mode=0, counting resumes from the same pcnt value;
   - THCSR=1 with dbg_mode=0 -> no halt.
